ravenoc_edge_term: RTL and testbench
====================================

RAVENOC_EDGE_TERM -- requirements
Module: ravenoc_edge_term

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 34: flit width in bits; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type (00 head, 01 body, 10 tail, 11 head_tail).
REQ-002 SHALL have parameter N_VC, default 2: virtual channel count, range 1..8; VC_W = max(1, $clog2(N_VC)).
REQ-003 SHALL have parameter MODE, default 1: 0 = passive tie-off, 1 = active sink with monitoring.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the flit and packet counters.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk_noc  in  1  NoC clock.
- arst_noc  in  1  asynchronous reset, active-low.
- recv_valid  in  1  flit valid from the neighbouring router.
- recv_vc  in  VC_W  VC of the offered flit.
- recv_flit  in  FLIT_WIDTH  flit payload.
- recv_ready  out  N_VC  per-VC ready.
- send_valid  out  1  outbound valid; always 0.
- send_vc  out  VC_W  always 0.
- send_flit  out  FLIT_WIDTH  always 0.
- err_clr  in  1  one-cycle pulse; clears the error state.
- cnt_clr  in  1  one-cycle pulse; clears the counters.
- err_irq  out  1  sticky error interrupt.
- err_code  out  3  sticky flags: [0] misrouted flit, [1] framing error, [2] illegal VC.
- flit_cnt  out  CNT_WIDTH  accepted flits.
- pkt_cnt  out  CNT_WIDTH  completed packets.
- open_pkt  out  N_VC  per-VC packet-in-progress.
- last_flit  out  FLIT_WIDTH  most recently accepted flit.

Function
REQ-006 With MODE=0, the block SHALL drive recv_ready=0 and hold every status output at its reset value permanently.
REQ-007 With MODE=1, recv_ready SHALL be all ones, combinationally, in every cycle outside reset.
REQ-008 A handshake SHALL occur when recv_valid=1, recv_vc<N_VC and recv_ready[recv_vc]=1; all state updates SHALL appear on the next clk_noc edge (latency 1).
REQ-009 When recv_valid=1 and recv_vc>=N_VC, the block SHALL perform no handshake, SHALL set err_code[2], and SHALL leave all other state unchanged.
REQ-010 Every handshake SHALL increment flit_cnt, SHALL load last_flit, and SHALL set err_code[0].
REQ-011 Each VC SHALL have a framing FSM with states IDLE and IN_PKT (open_pkt[v]=1 when in IN_PKT).
REQ-012 FSM transitions from IDLE:
- head: go to IN_PKT.
- head_tail: stay in IDLE, increment pkt_cnt.
- body or tail: stay in IDLE, set err_code[1].
REQ-013 FSM transitions from IN_PKT:
- body: stay in IN_PKT.
- tail: go to IDLE, increment pkt_cnt.
- head: stay in IN_PKT, set err_code[1].
- head_tail: go to IDLE, set err_code[1], no pkt_cnt increment.
REQ-014 flit_cnt and pkt_cnt SHALL saturate at all ones and SHALL NOT wrap.
REQ-015 err_irq SHALL equal the registered OR of err_code bits and SHALL remain set until cleared.
REQ-016 err_clr SHALL clear err_code and err_irq; if an error-setting event occurs in the same cycle, the set SHALL win.
REQ-017 cnt_clr SHALL zero flit_cnt and pkt_cnt; if a handshake occurs in the same cycle, the clear SHALL win and the increment SHALL be lost, while last_flit, err_code and the FSMs still update.
REQ-018 cnt_clr SHALL NOT affect the FSMs or open_pkt; err_clr SHALL NOT affect the counters.

Reset
REQ-019 While arst_noc=0, the block SHALL drive:
- all FSMs to IDLE;
- flit_cnt, pkt_cnt, err_code, err_irq, last_flit and open_pkt to 0;
- recv_ready to 0.
REQ-020 Reset assertion SHALL take effect asynchronously, including mid-packet; deassertion SHALL be used synchronised to clk_noc, and the first handshake is possible on the first edge after deassertion.

Verification
REQ-021 Scenario: MODE=1, VC0 receives head, body, tail on 3 consecutive cycles -> flit_cnt=3, pkt_cnt=1, open_pkt=00, err_code=001, err_irq=1.
REQ-022 Scenario: VC1 receives body while IDLE, then VC1 receives head followed by head -> err_code[1]=1, open_pkt[1]=1, pkt_cnt=0.
REQ-023 Scenario: with N_VC=2, VC_W=1 cannot encode an illegal VC, so N_VC=3 is used; recv_vc=3 with recv_valid=1 -> recv_ready unaffected, no counter change, err_code=100.
REQ-024 Scenario: CNT_WIDTH=4, 20 head_tail flits -> flit_cnt=15, pkt_cnt=15, with no wrap.
REQ-025 Scenario: err_clr asserted in the same cycle as a handshake -> err_code[0]=1 afterwards; err_clr alone on a later idle cycle -> err_code=000, err_irq=0.
REQ-026 Scenario: arst_noc asserted mid-packet on VC0 -> open_pkt=0 and counters=0 immediately; MODE=0 run with traffic -> recv_ready=0 and all status outputs stay 0.

Source files
------------

// File: rtl/ravenoc_edge_term.sv
// Edge-of-mesh terminator for a RaveNoC router port.
// Either ties the port off or sinks and monitors traffic.
module ravenoc_edge_term #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VC = 2,
  parameter int MODE = 1,
  parameter int CNT_WIDTH = 16,
  localparam int VC_W = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                  clk_noc,
  input  logic                  arst_noc,
  input  logic                  recv_valid,
  input  logic [VC_W-1:0]       recv_vc,
  input  logic [FLIT_WIDTH-1:0] recv_flit,
  output logic [N_VC-1:0]       recv_ready,
  output logic                  send_valid,
  output logic [VC_W-1:0]       send_vc,
  output logic [FLIT_WIDTH-1:0] send_flit,
  input  logic                  err_clr,
  input  logic                  cnt_clr,
  output logic                  err_irq,
  output logic [2:0]            err_code,
  output logic [CNT_WIDTH-1:0]  flit_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [N_VC-1:0]       open_pkt,
  output logic [FLIT_WIDTH-1:0] last_flit
);

  localparam bit ACTIVE = (MODE != 0);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } fsm_e;

  fsm_e st_q [N_VC];
  fsm_e st_d [N_VC];

  logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [2:0]            err_code_q, err_code_d;
  logic                  err_irq_q, err_irq_d;
  logic [FLIT_WIDTH-1:0] last_flit_q, last_flit_d;

  logic [31:0]     vc_ext;
  logic            vc_ok;
  logic            sel_rdy;
  logic            hs;
  logic            bad_vc;
  logic [1:0]      ftype;
  logic            is_head, is_body, is_tail, is_ht;
  logic [N_VC-1:0] frm_err_v;
  logic [N_VC-1:0] pkt_done_v;
  logic [2:0]      err_set;

  // Nothing is ever sent out of the mesh edge.
  assign send_valid = 1'b0;
  assign send_vc    = '0;
  assign send_flit  = '0;

  // Sink accepts on every VC whenever out of reset.
  always_comb begin
    recv_ready = '0;
    if (ACTIVE && arst_noc) begin
      recv_ready = '1;
    end
  end

  // Handshake qualification and flit-type decode.
  always_comb begin
    vc_ext  = 32'(recv_vc);
    vc_ok   = (vc_ext < 32'(N_VC));
    sel_rdy = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (vc_ext == 32'(v)) begin
        sel_rdy = recv_ready[v];
      end
    end
    hs      = recv_valid && vc_ok && sel_rdy;
    bad_vc  = ACTIVE && recv_valid && !vc_ok;
    ftype   = recv_flit[FLIT_WIDTH-1 -: 2];
    is_head = (ftype == 2'b00);
    is_body = (ftype == 2'b01);
    is_tail = (ftype == 2'b10);
    is_ht   = (ftype == 2'b11);
  end

  // Per-VC framing FSMs: next state, framing errors, packet ends.
  always_comb begin
    frm_err_v  = '0;
    pkt_done_v = '0;
    for (int v = 0; v < N_VC; v++) begin
      st_d[v] = st_q[v];
      if (hs && (vc_ext == 32'(v))) begin
        if (st_q[v] == IDLE) begin
          unique case (1'b1)
            is_head: st_d[v] = IN_PKT;
            is_ht:   pkt_done_v[v] = 1'b1;
            is_body,
            is_tail: frm_err_v[v] = 1'b1;
            default: st_d[v] = IDLE;
          endcase
        end else begin
          unique case (1'b1)
            is_body: st_d[v] = IN_PKT;
            is_tail: begin
              st_d[v]       = IDLE;
              pkt_done_v[v] = 1'b1;
            end
            is_head: frm_err_v[v] = 1'b1;
            is_ht: begin
              st_d[v]      = IDLE;
              frm_err_v[v] = 1'b1;
            end
            default: st_d[v] = IN_PKT;
          endcase
        end
      end
    end
  end

  // Counters, sticky errors and last-flit capture.
  always_comb begin
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (cnt_clr) begin
      flit_cnt_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      if (hs && (flit_cnt_q != '1)) begin
        flit_cnt_d = flit_cnt_q + 1'b1;
      end
      if ((|pkt_done_v) && (pkt_cnt_q != '1)) begin
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end
    err_set = {bad_vc, |frm_err_v, hs};
    if (err_clr) begin
      err_code_d = err_set;
    end else begin
      err_code_d = err_code_q | err_set;
    end
    err_irq_d   = |err_code_d;
    last_flit_d = last_flit_q;
    if (hs) begin
      last_flit_d = recv_flit;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      for (int v = 0; v < N_VC; v++) begin
        st_q[v] <= IDLE;
      end
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      err_code_q  <= '0;
      err_irq_q   <= 1'b0;
      last_flit_q <= '0;
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        st_q[v] <= st_d[v];
      end
      flit_cnt_q  <= flit_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_code_q  <= err_code_d;
      err_irq_q   <= err_irq_d;
      last_flit_q <= last_flit_d;
    end
  end

  // Status outputs.
  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      open_pkt[v] = (st_q[v] == IN_PKT);
    end
    flit_cnt  = flit_cnt_q;
    pkt_cnt   = pkt_cnt_q;
    err_code  = err_code_q;
    err_irq   = err_irq_q;
    last_flit = last_flit_q;
  end

endmodule

// File: tb/tb_ravenoc_edge_term.sv
// Directed bench for ravenoc_edge_term.
// Three instances: default sink, 3-VC/4-bit sink, passive tie-off.
module tb_ravenoc_edge_term;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vd, vs, vp;
  logic [1:0]  vc;
  logic [33:0] flit;
  logic        err_clr, cnt_clr;
  logic [33:0] exp_last;
  int          seq;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic [1:0]  d_rdy;
  logic        d_sv;
  logic [0:0]  d_svc;
  logic [33:0] d_sf;
  logic        d_irq;
  logic [2:0]  d_err;
  logic [15:0] d_fc, d_pc;
  logic [1:0]  d_open;
  logic [33:0] d_last;

  logic [2:0]  s_rdy;
  logic        s_sv;
  logic [1:0]  s_svc;
  logic [33:0] s_sf;
  logic        s_irq;
  logic [2:0]  s_err;
  logic [3:0]  s_fc, s_pc;
  logic [2:0]  s_open;
  logic [33:0] s_last;

  logic [1:0]  p_rdy;
  logic        p_sv;
  logic [0:0]  p_svc;
  logic [33:0] p_sf;
  logic        p_irq;
  logic [2:0]  p_err;
  logic [15:0] p_fc, p_pc;
  logic [1:0]  p_open;
  logic [33:0] p_last;

  ravenoc_edge_term u_d (
    .clk_noc(clk), .arst_noc(rst_n),
    .recv_valid(vd), .recv_vc(vc[0:0]), .recv_flit(flit),
    .recv_ready(d_rdy), .send_valid(d_sv), .send_vc(d_svc),
    .send_flit(d_sf), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .err_irq(d_irq), .err_code(d_err), .flit_cnt(d_fc),
    .pkt_cnt(d_pc), .open_pkt(d_open), .last_flit(d_last)
  );

  ravenoc_edge_term #(.N_VC(3), .CNT_WIDTH(4)) u_s (
    .clk_noc(clk), .arst_noc(rst_n),
    .recv_valid(vs), .recv_vc(vc), .recv_flit(flit),
    .recv_ready(s_rdy), .send_valid(s_sv), .send_vc(s_svc),
    .send_flit(s_sf), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .err_irq(s_irq), .err_code(s_err), .flit_cnt(s_fc),
    .pkt_cnt(s_pc), .open_pkt(s_open), .last_flit(s_last)
  );

  ravenoc_edge_term #(.MODE(0)) u_p (
    .clk_noc(clk), .arst_noc(rst_n),
    .recv_valid(vp), .recv_vc(vc[0:0]), .recv_flit(flit),
    .recv_ready(p_rdy), .send_valid(p_sv), .send_vc(p_svc),
    .send_flit(p_sf), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .err_irq(p_irq), .err_code(p_err), .flit_cnt(p_fc),
    .pkt_cnt(p_pc), .open_pkt(p_open), .last_flit(p_last)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; outputs are settled 1ns after the edge.
  task automatic step(input logic v_d, input logic v_s,
                      input logic [1:0] c, input logic [1:0] t,
                      input logic ec, input logic cc);
    vd      = v_d;
    vs      = v_s;
    vp      = v_d | v_s;
    vc      = c;
    flit    = {t, 32'h5A5A_0000 | 32'(seq)};
    seq++;
    err_clr = ec;
    cnt_clr = cc;
    @(posedge clk);
    #1;
    vd      = 1'b0;
    vs      = 1'b0;
    vp      = 1'b0;
    err_clr = 1'b0;
    cnt_clr = 1'b0;
  endtask

  localparam logic [1:0] HD = 2'b00;
  localparam logic [1:0] BD = 2'b01;
  localparam logic [1:0] TL = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  initial begin
    rst_n   = 1'b0;
    vd      = 1'b0;
    vs      = 1'b0;
    vp      = 1'b0;
    vc      = '0;
    flit    = '0;
    err_clr = 1'b0;
    cnt_clr = 1'b0;
    seq     = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", d_rdy, 2'b00);
    chk("rst_fc", d_fc, 16'd0);
    chk("rst_err", d_err, 3'b000);
    chk("rst_open", d_open, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("rdy_d", d_rdy, 2'b11);
    chk("rdy_s", s_rdy, 3'b111);
    chk("rdy_p", p_rdy, 2'b00);
    chk("send", {d_sv, d_svc, d_sf}, 64'd0);

    // head, body, tail on VC0
    step(1'b1, 1'b0, 2'd0, HD, 1'b0, 1'b0);
    chk("hbt_open1", d_open, 2'b01);
    step(1'b1, 1'b0, 2'd0, BD, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, TL, 1'b0, 1'b0);
    exp_last = {TL, 32'h5A5A_0003};
    chk("hbt_fc", d_fc, 16'd3);
    chk("hbt_pc", d_pc, 16'd1);
    chk("hbt_open", d_open, 2'b00);
    chk("hbt_err", d_err, 3'b001);
    chk("hbt_irq", d_irq, 1'b1);
    chk("hbt_last", d_last, exp_last);

    // counter clear alone
    step(1'b0, 1'b0, 2'd0, HD, 1'b0, 1'b1);
    chk("cclr_fc", d_fc, 16'd0);
    chk("cclr_pc", d_pc, 16'd0);
    chk("cclr_err", d_err, 3'b001);

    // framing errors on VC1
    step(1'b1, 1'b0, 2'd1, BD, 1'b0, 1'b0);
    chk("frm_body", d_err, 3'b011);
    chk("frm_open0", d_open, 2'b00);
    step(1'b1, 1'b0, 2'd1, HD, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd1, HD, 1'b0, 1'b0);
    chk("frm_err", d_err, 3'b011);
    chk("frm_open", d_open, 2'b10);
    chk("frm_pc", d_pc, 16'd0);
    chk("frm_fc", d_fc, 16'd3);
    step(1'b1, 1'b0, 2'd1, HT, 1'b0, 1'b0);
    chk("ht_inpkt_open", d_open, 2'b00);
    chk("ht_inpkt_pc", d_pc, 16'd0);

    // err_clr with a handshake: set wins
    step(1'b1, 1'b0, 2'd0, HT, 1'b1, 1'b0);
    chk("eclr_hs_err", d_err, 3'b001);
    chk("eclr_hs_irq", d_irq, 1'b1);
    chk("eclr_hs_pc", d_pc, 16'd1);
    chk("eclr_hs_fc", d_fc, 16'd5);
    step(1'b0, 1'b0, 2'd0, HD, 1'b1, 1'b0);
    chk("eclr_err", d_err, 3'b000);
    chk("eclr_irq", d_irq, 1'b0);
    chk("eclr_fc", d_fc, 16'd5);

    // cnt_clr with a handshake: clear wins, rest updates
    step(1'b1, 1'b0, 2'd0, HD, 1'b0, 1'b1);
    exp_last = {HD, 32'h5A5A_0000 | 32'(seq - 1)};
    chk("cclr_hs_fc", d_fc, 16'd0);
    chk("cclr_hs_pc", d_pc, 16'd0);
    chk("cclr_hs_open", d_open, 2'b01);
    chk("cclr_hs_err", d_err, 3'b001);
    chk("cclr_hs_last", d_last, exp_last);
    step(1'b1, 1'b0, 2'd0, BD, 1'b0, 1'b0);
    chk("mid_fc", d_fc, 16'd1);

    // asynchronous reset mid-packet
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_open", d_open, 2'b00);
    chk("arst_fc", d_fc, 16'd0);
    chk("arst_err", d_err, 3'b000);
    chk("arst_last", d_last, 64'd0);
    chk("arst_rdy", d_rdy, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // illegal VC on the 3-VC instance
    vs = 1'b1;
    vc = 2'd3;
    #1;
    chk("ivc_rdy", s_rdy, 3'b111);
    vs = 1'b0;
    step(1'b0, 1'b1, 2'd3, HD, 1'b0, 1'b0);
    chk("ivc_err", s_err, 3'b100);
    chk("ivc_fc", s_fc, 4'd0);
    chk("ivc_open", s_open, 3'b000);
    chk("ivc_last", s_last, 64'd0);

    // saturation with 4-bit counters
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 2'd2, HT, 1'b0, 1'b0);
    end
    chk("sat_fc", s_fc, 4'hF);
    chk("sat_pc", s_pc, 4'hF);
    chk("sat_err", s_err, 3'b101);

    // passive instance saw all the traffic
    chk("pas_rdy", p_rdy, 2'b00);
    chk("pas_cnt", {p_fc, p_pc}, 32'd0);
    chk("pas_err", {p_irq, p_err}, 4'd0);
    chk("pas_open", p_open, 2'b00);
    chk("pas_last", p_last, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
